// File: rtl/config_frame_loader.sv
// Serial-to-parallel config frame loader feeding NUM_BLOCKS latch blocks in turn.
// Optional even-parity check per frame: define CONFIG_LOADER_PARITY_EN.
module config_frame_loader #(
    parameter int ADDR_BITS  = 4,
    parameter int MEM_SIZE   = 2**ADDR_BITS,
    parameter int NUM_BLOCKS = 4
) (
    input  logic                  cclk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  bit_in,
    input  logic                  bit_valid,
    output logic                  bit_ready,
    output logic [MEM_SIZE-1:0]   cfg_word,
    output logic [NUM_BLOCKS-1:0] cen,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int CNT_W = $clog2(MEM_SIZE + 1);
    localparam int IDX_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
`ifdef CONFIG_LOADER_PARITY_EN
    localparam int LAST = MEM_SIZE;
`else
    localparam int LAST = MEM_SIZE - 1;
`endif
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BLOCKS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [MEM_SIZE-1:0] word_q, word_d;
`ifdef CONFIG_LOADER_PARITY_EN
    logic                err_q, err_d;
    logic                par_q, par_d;
`endif

    always_ff @(posedge cclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            word_q  <= '0;
`ifdef CONFIG_LOADER_PARITY_EN
            err_q   <= 1'b0;
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
`ifdef CONFIG_LOADER_PARITY_EN
            err_q   <= err_d;
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        word_d  = word_q;
`ifdef CONFIG_LOADER_PARITY_EN
        err_d   = err_q;
        par_d   = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    idx_d   = '0;
                    cnt_d   = '0;
`ifdef CONFIG_LOADER_PARITY_EN
                    err_d   = 1'b0;
                    par_d   = 1'b0;
`endif
                end
            end
            SHIFT: begin
                if (bit_valid) begin
                    cnt_d = cnt_q + CNT_W'(1);
`ifdef CONFIG_LOADER_PARITY_EN
                    par_d = par_q ^ bit_in;
                    // parity bit is checked but never shifted into the frame
                    if (cnt_q != LAST_CNT)
                        word_d = {bit_in, word_q[MEM_SIZE-1:1]};
                    if (cnt_q == LAST_CNT) begin
                        if (par_q ^ bit_in) begin
                            state_d = IDLE;
                            err_d   = 1'b1;
                        end else begin
                            state_d = COMMIT;
                        end
                    end
`else
                    word_d = {bit_in, word_q[MEM_SIZE-1:1]};
                    if (cnt_q == LAST_CNT)
                        state_d = COMMIT;
`endif
                end
            end
            COMMIT: begin
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    state_d = SHIFT;
                    idx_d   = idx_q + IDX_W'(1);
                    cnt_d   = '0;
`ifdef CONFIG_LOADER_PARITY_EN
                    par_d   = 1'b0;
`endif
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bit_ready = (state_q == SHIFT);
    assign busy      = (state_q == SHIFT) || (state_q == COMMIT);
    assign done      = (state_q == DONE);
    assign cfg_word  = word_q;
    assign cen       = (state_q == COMMIT) ? (NUM_BLOCKS'(1) << idx_q) : '0;
`ifdef CONFIG_LOADER_PARITY_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif

endmodule
